// File: rtl/sspis_pkg.sv
// Shared definitions for the SPI-slave register port to Wishbone master bridge.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
package sspis_pkg;

  // Bridge sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default abort budget in Wishbone cycles, and the read data returned on abort.
  localparam int          TIMEOUT_CYC_DEF = 1023;
  localparam logic [31:0] TO_RDATA_DEF    = 32'hDEAD_0BAD;

  // Command codes derived from the request levels.
  localparam logic [3:0] CMD_READ  = 4'h1;
  localparam logic [3:0] CMD_WRITE = 4'h2;

  // Writes honour the requester's byte enables; reads always fetch the full word.
  function automatic logic [3:0] cmd_sel(input logic [3:0] cmd, input logic [3:0] be);
    return (cmd == CMD_WRITE) ? be : 4'hF;
  endfunction

endpackage

// File: rtl/sspis_wbm.sv
// Bridges SPI-slave register read/write request levels onto a single Wishbone master cycle.
// Latency: request seen in cycle 0 -> cyc in cycle 1; ack/err/timeout in cycle k -> reg_ack in cycle k+1.
// Backpressure: requester holds its level until reg_ack; slave stalls via ack/err, bounded by TIMEOUT_CYC.
module sspis_wbm
  import sspis_pkg::*;
#(
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [31:0] TO_RDATA    = TO_RDATA_DEF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [31:0] reg_addr,
  input  logic [3:0]  reg_be,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        err_clr,
  output logic [1:0]  err_sticky
);

  // Sized so the counter can hold TIMEOUT_CYC; the abort at TIMEOUT_CYC-1 keeps it from wrapping.
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cyc;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [3:0]       r_sel;
  logic [31:0]      r_dat;
  logic [31:0]      r_rdata;
  logic             r_ack;
  logic [1:0]       r_err;

  logic [3:0]       w_cmd;
  logic             w_in_bus;
  logic             w_bus_err;
  logic             w_timeout;
  logic             w_finish;
  logic [1:0]       w_err_set;

  // A request with both levels high is a write.
  assign w_cmd     = reg_wr ? CMD_WRITE : CMD_READ;
  assign w_in_bus  = (r_state == ST_BUS);
  // err wins over ack when both arrive together.
  assign w_bus_err = w_in_bus && wbm_err_i;
  // Timeout only counts when the slave gave no answer at all this cycle.
  assign w_timeout = w_in_bus && !wbm_ack_i && !wbm_err_i && (r_cnt == CNT_LAST);
  assign w_finish  = w_in_bus && (wbm_ack_i || wbm_err_i || w_timeout);
  assign w_err_set = {w_timeout, w_bus_err};

  // Sequencer: launch the bus cycle, hold it stable, close it on ack/err/timeout.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (reg_wr || reg_rd) begin
            r_we    <= (w_cmd == CMD_WRITE);
            r_adr   <= reg_addr;
            r_dat   <= reg_wdata;
            r_sel   <= cmd_sel(w_cmd, reg_be);
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_BUS;
          end
        end
        ST_BUS: begin
          // The request level is not looked at here: an SPI abort still lets the cycle finish.
          if (w_finish) begin
            r_cyc   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= ST_DONE;
            if (!r_we) begin
              r_rdata <= (w_bus_err || w_timeout) ? TO_RDATA : wbm_dat_i;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // The requester's level is still high here while it reacts to reg_ack.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags: a new event in the clear cycle survives the clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= (r_err & ~{2{err_clr}}) | w_err_set;
    end
  end

  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
  assign wbm_we_o   = r_we;
  assign wbm_adr_o  = r_adr;
  assign wbm_sel_o  = r_sel;
  assign wbm_dat_o  = r_dat;
  assign reg_rdata  = r_rdata;
  assign reg_ack    = r_ack;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_sspis_wbm.sv
// Directed bench for sspis_wbm: a vector table of single transactions plus hand-written corner sequences.
// Latency: checks request->cyc in one cycle and ack->reg_ack in one cycle.
// Backpressure: a slave model answers with ack/err/none after a per-vector wait count.
module tb_sspis_wbm;
  import sspis_pkg::*;

  localparam int          R_ACK  = 0;
  localparam int          R_ERR  = 1;
  localparam int          R_NONE = 2;
  localparam int          R_BOTH = 3;
  localparam logic [31:0] BAD    = 32'hDEAD_0BAD;

  logic        sys_clk;
  logic        rst_n;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_addr;
  logic [3:0]  reg_be;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        err_clr;
  logic [1:0]  err_sticky;

  sspis_wbm #(.TIMEOUT_CYC(16)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_be     (reg_be),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i),
    .err_clr    (err_clr),
    .err_sticky (err_sticky)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          resp;
    int          waits;
    logic [31:0] sdat;
    int          abort_at;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_ack_cyc;
    int          exp_cyc_n;
  } vec_t;

  vec_t vecs[10];
  vec_t vb;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-transaction observations.
  int          m_first;
  int          m_cycn;
  int          m_ackn;
  int          m_ackc;
  logic        m_stable;
  logic        m_stbok;
  logic [31:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic        m_we;
  logic [31:0] m_rdata;
  logic [1:0]  m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one request from cycle 0, plays the slave, and records what the bus did.
  task automatic txn(input vec_t v, input int tail);
    int w;
    int drop_at;
    w        = 0;
    drop_at  = (v.abort_at > 0) ? v.abort_at : -1;
    m_first  = -1;
    m_cycn   = 0;
    m_ackn   = 0;
    m_ackc   = -1;
    m_stable = 1'b1;
    m_stbok  = 1'b1;
    m_adr    = '0;
    m_dat    = '0;
    m_sel    = '0;
    m_we     = 1'b0;
    m_rdata  = '0;
    m_err    = '0;
    reg_wr    = v.wr;
    reg_rd    = v.rd;
    reg_addr  = v.addr;
    reg_be    = v.be;
    reg_wdata = v.wdata;
    wbm_dat_i = v.sdat;
    for (int c = 1; c <= 80; c++) begin
      @(posedge sys_clk);
      #1;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (c == drop_at) begin
        reg_wr = 1'b0;
        reg_rd = 1'b0;
      end
      if (wbm_cyc_o !== wbm_stb_o) m_stbok = 1'b0;
      if (wbm_cyc_o === 1'b1) begin
        if (m_first < 0) begin
          m_first = c;
          m_adr   = wbm_adr_o;
          m_dat   = wbm_dat_o;
          m_sel   = wbm_sel_o;
          m_we    = wbm_we_o;
        end else if (wbm_adr_o !== m_adr || wbm_dat_o !== m_dat ||
                     wbm_sel_o !== m_sel || wbm_we_o !== m_we) begin
          m_stable = 1'b0;
        end
        m_cycn++;
        if (w == v.waits) begin
          case (v.resp)
            R_ACK:   wbm_ack_i = 1'b1;
            R_ERR:   wbm_err_i = 1'b1;
            R_BOTH:  begin wbm_ack_i = 1'b1; wbm_err_i = 1'b1; end
            default: ;
          endcase
        end
        w++;
      end
      if (reg_ack === 1'b1) begin
        m_ackn++;
        m_ackc  = c;
        m_rdata = reg_rdata;
        m_err   = err_sticky;
        drop_at = c + 1;
      end
      if (m_ackc > 0 && c >= m_ackc + tail) break;
    end
    reg_wr = 1'b0;
    reg_rd = 1'b0;
  endtask

  task automatic check_txn(input string nm, input vec_t v);
    chk({nm, "_cyc_start"}, 32'(m_first), 32'd1);
    chk({nm, "_cyc_len"},   32'(m_cycn), 32'(v.exp_cyc_n));
    chk({nm, "_ack_cnt"},   32'(m_ackn), 32'd1);
    chk({nm, "_ack_cyc"},   32'(m_ackc), 32'(v.exp_ack_cyc));
    chk({nm, "_adr"},       m_adr, v.addr);
    chk({nm, "_dat"},       m_dat, v.wdata);
    chk({nm, "_sel"},       32'(m_sel), 32'(v.exp_sel));
    chk({nm, "_we"},        32'(m_we), 32'(v.exp_we));
    chk({nm, "_stable"},    32'(m_stable), 32'd1);
    chk({nm, "_stb_eq"},    32'(m_stbok), 32'd1);
    chk({nm, "_rdata"},     m_rdata, v.exp_rdata);
    chk({nm, "_err"},       32'(m_err), 32'(v.exp_err));
  endtask

  task automatic clear_err(input string nm);
    err_clr = 1'b1;
    @(posedge sys_clk);
    #1;
    err_clr = 1'b0;
    chk({nm, "_err_clr"}, 32'(err_sticky), 32'd0);
  endtask

  initial begin
    int acks;
    //            wr    rd    addr          be     wdata         resp    w  sdat          ab  we    sel    rdata         err    ack cyc
    vecs[0] = '{1'b1, 1'b0, 32'h3000_0010, 4'h3, 32'h1234_5678, R_ACK,  3, 32'h0,        0, 1'b1, 4'h3, 32'h0,        2'b00, 5,  4};
    vecs[1] = '{1'b0, 1'b1, 32'h3000_0020, 4'h0, 32'h0,        R_ACK,  0, 32'hCAFE_F00D, 0, 1'b0, 4'hF, 32'hCAFE_F00D, 2'b00, 2,  1};
    vecs[2] = '{1'b1, 1'b0, 32'h3000_0030, 4'hC, 32'hAABB_CCDD, R_ACK,  1, 32'h9999_9999, 0, 1'b1, 4'hC, 32'hCAFE_F00D, 2'b00, 3,  2};
    vecs[3] = '{1'b0, 1'b1, 32'h3000_0040, 4'h0, 32'h0,        R_ERR,  2, 32'h1111_1111, 0, 1'b0, 4'hF, BAD,          2'b01, 4,  3};
    vecs[4] = '{1'b0, 1'b1, 32'h3000_0050, 4'h0, 32'h0,        R_NONE, 0, 32'h2222_2222, 0, 1'b0, 4'hF, BAD,          2'b10, 17, 16};
    vecs[5] = '{1'b1, 1'b1, 32'h3000_0060, 4'h5, 32'h0F0F_0F0F, R_ACK,  0, 32'h3333_3333, 0, 1'b1, 4'h5, BAD,          2'b00, 2,  1};
    vecs[6] = '{1'b0, 1'b1, 32'h3000_0070, 4'h0, 32'h0,        R_ACK,  1, 32'h1357_9BDF, 0, 1'b0, 4'hF, 32'h1357_9BDF, 2'b00, 3,  2};
    vecs[7] = '{1'b1, 1'b0, 32'h3000_0080, 4'hF, 32'h5A5A_5A5A, R_ERR,  0, 32'h4444_4444, 0, 1'b1, 4'hF, 32'h1357_9BDF, 2'b01, 2,  1};
    vecs[8] = '{1'b0, 1'b1, 32'h3000_0090, 4'h0, 32'h0,        R_BOTH, 0, 32'h5555_5555, 0, 1'b0, 4'hF, BAD,          2'b01, 2,  1};
    vecs[9] = '{1'b0, 1'b1, 32'h3000_00A0, 4'h0, 32'h0,        R_ACK,  4, 32'h2468_ACE0, 2, 1'b0, 4'hF, 32'h2468_ACE0, 2'b00, 6,  5};

    rst_n     = 1'b0;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    reg_addr  = '0;
    reg_be    = '0;
    reg_wdata = '0;
    wbm_dat_i = '0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    err_clr   = 1'b0;

    // Reset state.
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_cyc",   32'(wbm_cyc_o), 32'd0);
    chk("rst_stb",   32'(wbm_stb_o), 32'd0);
    chk("rst_we",    32'(wbm_we_o), 32'd0);
    chk("rst_adr",   wbm_adr_o, 32'd0);
    chk("rst_dat",   wbm_dat_o, 32'd0);
    chk("rst_sel",   32'(wbm_sel_o), 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_ack",   32'(reg_ack), 32'd0);
    chk("rst_err",   32'(err_sticky), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Vector table: each request is held through its reg_ack cycle, then three idle cycles follow.
    for (int i = 0; i < 10; i++) begin
      txn(vecs[i], 3);
      check_txn($sformatf("v%0d", i), vecs[i]);
      clear_err($sformatf("v%0d", i));
    end

    // Back-to-back: second request presented in the IDLE cycle right after DONE.
    vb = '{1'b1, 1'b0, 32'h3000_0100, 4'h9, 32'hFEED_BEEF, R_ACK, 1, 32'h0, 0, 1'b1, 4'h9, 32'h2468_ACE0, 2'b00, 3, 2};
    txn(vb, 1);
    check_txn("b2b_first", vb);
    vb = '{1'b0, 1'b1, 32'h3000_0104, 4'h0, 32'h0, R_ACK, 0, 32'h7777_1234, 0, 1'b0, 4'hF, 32'h7777_1234, 2'b00, 2, 1};
    txn(vb, 3);
    check_txn("b2b_second", vb);

    // Bus error in the same cycle as err_clr: the new error survives.
    reg_rd   = 1'b1;
    reg_addr = 32'h3000_0200;
    @(posedge sys_clk);
    #1;
    chk("setclr_cyc", 32'(wbm_cyc_o), 32'd1);
    reg_rd    = 1'b0;
    wbm_err_i = 1'b1;
    err_clr   = 1'b1;
    @(posedge sys_clk);
    #1;
    wbm_err_i = 1'b0;
    err_clr   = 1'b0;
    chk("setclr_ack", 32'(reg_ack), 32'd1);
    chk("setclr_err", 32'(err_sticky), 32'd1);
    chk("setclr_rdata", reg_rdata, BAD);
    @(posedge sys_clk);
    #1;
    clear_err("setclr");

    // Reset during BUS: cyc drops without a clock edge and no reg_ack follows.
    reg_wr    = 1'b1;
    reg_addr  = 32'h3000_0300;
    reg_be    = 4'hF;
    reg_wdata = 32'h0BAD_CAFE;
    @(posedge sys_clk);
    #1;
    chk("arst_cyc_before", 32'(wbm_cyc_o), 32'd1);
    @(posedge sys_clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("arst_stb", 32'(wbm_stb_o), 32'd0);
    chk("arst_ack", 32'(reg_ack), 32'd0);
    chk("arst_adr", wbm_adr_o, 32'd0);
    reg_wr = 1'b0;
    @(posedge sys_clk);
    #3;
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge sys_clk);
      #1;
      if (reg_ack === 1'b1) acks++;
    end
    chk("arst_no_ack", 32'(acks), 32'd0);
    vb = '{1'b0, 1'b1, 32'h3000_0304, 4'h0, 32'h0, R_ACK, 0, 32'h0F1E_2D3C, 0, 1'b0, 4'hF, 32'h0F1E_2D3C, 2'b00, 2, 1};
    txn(vb, 3);
    check_txn("arst_after", vb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
